// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with a 2-entry skid buffer, registered ready, stall and flush-to-NOP.
// Optional perf counters are compiled in with `define PIPE_STAGE_REG_PERF_EN.
module pipe_stage_reg #(
    parameter int          PC_W      = 32,
    parameter int          DATA_W    = 32,
    parameter int          STAGE_IDX = 1,
    parameter int          STALL_W   = 6,
    parameter int          FLUSH_W   = 6,
    parameter logic [31:0] NOP_INS   = 32'h00000013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_i,
    input  logic [FLUSH_W-1:0] flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [PC_W-1:0]    pc_i,
    input  logic [DATA_W-1:0]  ins_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [PC_W-1:0]    pc_o,
    output logic [DATA_W-1:0]  ins_o,
    output logic               bubble_o
`ifdef PIPE_STAGE_REG_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt_o,
    output logic [31:0]        perf_flush_cnt_o
`endif
);

    typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_e;

    localparam logic [DATA_W-1:0] NOP_D = DATA_W'(NOP_INS);

    state_e            state, state_nxt;
    logic [PC_W-1:0]   skid_pc;
    logic [DATA_W-1:0] skid_ins;
    logic              stall, flush, fire_in, accept;

    assign stall   = stall_i[STAGE_IDX];
    assign flush   = flush_i[STAGE_IDX];
    assign fire_in = in_valid_i & in_ready_o;
    assign accept  = out_valid_o & out_ready_i & ~stall;

    // Only this stage's bits matter; the rest of each bus belongs to other stages.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{stall_i, flush_i};

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = FULL;
        end else begin
            case (state)
                EMPTY:   if (fire_in) state_nxt = FULL;
                FULL: begin
                    if (fire_in && !accept)      state_nxt = SKID;
                    else if (!fire_in && accept) state_nxt = EMPTY;
                end
                SKID:    if (accept) state_nxt = FULL;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Both handshake outputs come straight from the state register.
    always_comb begin
        out_valid_o = (state != EMPTY);
        in_ready_o  = (state != SKID);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_o     <= '0;
            ins_o    <= NOP_D;
            bubble_o <= 1'b0;
            skid_pc  <= '0;
            skid_ins <= '0;
        end else if (flush) begin
            ins_o    <= NOP_D;
            bubble_o <= 1'b1;
        end else begin
            case (state)
                EMPTY, FULL: begin
                    if (fire_in && (state == EMPTY || accept)) begin
                        pc_o     <= pc_i;
                        ins_o    <= ins_i;
                        bubble_o <= 1'b0;
                    end else if (fire_in) begin
                        skid_pc  <= pc_i;
                        skid_ins <= ins_i;
                    end
                end
                SKID: begin
                    if (accept) begin
                        pc_o     <= skid_pc;
                        ins_o    <= skid_ins;
                        bubble_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PIPE_STAGE_REG_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt_o <= '0;
            perf_flush_cnt_o <= '0;
        end else begin
            if (out_valid_o && stall) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            if (flush)                perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised elastic pipeline register for any inter-stage boundary in the RISC-V core (IF/ID, ID/EX, ...). Carries PC and instruction words with a valid/ready handshake. A 2-entry skid buffer lets the upstream stage see a registered ready, so there is no combinational ready path through the pipeline. Per-stage stall and flush bits come from the shared stall/flush buses; flush injects a NOP bubble.

Parameters:
PC_W, 32, width of PC field
DATA_W, 32, width of instruction/data field
STAGE_IDX, 1, bit index used in stall_i and flush_i
STALL_W, 6, width of stall bus
FLUSH_W, 6, width of flush bus
NOP_INS, 32'h00000013, value injected on flush/reset (addi x0,x0,0); truncated or zero-extended to DATA_W

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stall_i  in  STALL_W  stall bus; bit STAGE_IDX holds this stage
flush_i  in  FLUSH_W  flush bus; bit STAGE_IDX flushes this stage
in_valid_i  in  1  upstream entry valid
in_ready_o  out  1  stage can accept; registered
pc_i  in  PC_W  upstream PC
ins_i  in  DATA_W  upstream instruction
out_valid_o  out  1  output entry valid
out_ready_i  in  1  downstream accepts
pc_o  out  PC_W  registered PC
ins_o  out  DATA_W  registered instruction
bubble_o  out  1  output entry is an injected NOP

Behaviour:
- fire_in = in_valid_i & in_ready_o. accept = out_valid_o & out_ready_i & ~stall_i[STAGE_IDX].
- in_ready_o = ~skid_valid. This is a registered state bit, not a combinational function of out_ready_i.
- States: EMPTY (main and skid empty), FULL (main valid), SKID (main and skid valid).
- EMPTY: if fire_in, load main from the inputs, set bubble_o=0, go to FULL.
- FULL, fire_in & accept: load main from the inputs, stay FULL.
- FULL, fire_in & ~accept: capture the inputs in skid, go to SKID.
- FULL, ~fire_in & accept: out_valid_o<=0, go to EMPTY. pc_o/ins_o hold their last values.
- FULL, ~fire_in & ~accept: hold.
- SKID: no fire_in is possible. On accept, move skid to main, clear skid, go to FULL. Otherwise hold.
- Latency: 1 cycle from fire_in to out_valid_o when the stage is empty or draining. Throughput is 1 entry/cycle when unstalled.
- Stall: stall_i[STAGE_IDX]=1 blocks accept only. Upstream can still fill the skid, then in_ready_o drops.
- Flush (flush_i[STAGE_IDX]=1), every state:
  - ins_o<=NOP_INS, bubble_o<=1, out_valid_o<=1; pc_o unchanged.
  - Skid cleared (in_ready_o=1 next cycle); any fire_in in the same cycle is discarded.
  - Next state FULL.
- Priority: rst > flush > stall/handshake. Flush overrides a simultaneous stall.
- Reset (also mid-operation): pc_o=0, ins_o=NOP_INS, bubble_o=0, out_valid_o=0, skid cleared, in_ready_o=1, state EMPTY. In-flight entries are dropped.
- Ordering: entries leave in arrival order; none are duplicated or lost except by flush/reset.
- Unused stall/flush bits are ignored.

Optional Feature:
- Macro PIPE_STAGE_REG_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt_o[31:0] and perf_flush_cnt_o[31:0].
  - perf_stall_cnt_o increments each cycle out_valid_o & stall_i[STAGE_IDX].
  - perf_flush_cnt_o increments each cycle flush_i[STAGE_IDX].
  - Both wrap at 2^32 (32'hFFFFFFFF -> 0) and are cleared by rst.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then in_valid_i=1, pc_i=0x100, ins_i=0x00500093, out_ready_i=1 each cycle -> out_valid_o=1 one cycle later with pc_o=0x100, ins_o=0x00500093; stream of 4 entries emerges back-to-back in order.
- FULL with pc 0x104, out_ready_i=0, new entry pc 0x108 fires -> in_ready_o=0 next cycle. Raise out_ready_i -> 0x104 then 0x108 are output on consecutive cycles, and in_ready_o returns to 1.
- stall_i[1]=1 for 3 cycles with out_ready_i=1 -> pc_o/ins_o held, no entry lost; entry count out = entry count in.
- Flush in SKID state with a simultaneous stall and fire_in (pc 0x10C) -> next cycle ins_o=0x00000013, bubble_o=1, pc_o unchanged, in_ready_o=1; 0x10C never appears.
- rst asserted while in SKID -> next cycle out_valid_o=0, ins_o=0x00000013, pc_o=0, in_ready_o=1.
- With PIPE_STAGE_REG_PERF_EN: 5 stalled valid cycles, 2 flushes -> perf_stall_cnt_o=5, perf_flush_cnt_o=2; preload 32'hFFFFFFFF then one flush -> 0.
